// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port synchronous framebuffer RAM between VGA scan-out and a
// pixel writer. Scan-out reads are prefetched three cycles ahead of the beam, on
// the first screen pixel of every framebuffer pixel, and always win the RAM.
// Every other cycle is offered to the writer, which sees a combinational ack.
// Data path: decide (p0) -> RAM port registers (p1) -> RAM data out (p2) -> pixReg.
module vga_fb_arbiter #(
    parameter int SCREEN_X    = 1024,
    parameter int SCREEN_Y    = 768,
    parameter int H_PERIOD    = 1329,
    parameter int V_PERIOD    = 807,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_W        = 256,
    parameter int FB_H        = 192,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       posX,
    input  logic [11:0]       posY,
    output logic [DATA_W-1:0] pix_out,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Prefetch distance: decide, drive address, RAM access, capture.
    localparam logic [12:0] LEAD      = 13'd3;
    localparam logic [12:0] H_P       = 13'(H_PERIOD);
    localparam logic [12:0] V_P       = 13'(V_PERIOD);
    localparam logic [12:0] SX_TGT    = 13'(SCREEN_X);
    localparam logic [12:0] SY_TGT    = 13'(SCREEN_Y);
    localparam logic [11:0] SX_VIS    = 12'(SCREEN_X);
    localparam logic [11:0] SY_VIS    = 12'(SCREEN_Y);
    localparam logic [31:0] FB_PIXELS = 32'(FB_W * FB_H);

    // One extra bit so posX+LEAD and posY+1 never overflow before the wrap test.
    logic [12:0]       nxRaw_p0;
    logic [12:0]       nyInc_p0;
    logic [12:0]       nx_p0;
    logic [12:0]       ny_p0;
    logic              readSlot_p0;
    logic [ADDR_W-1:0] rdAddr_p0;
    logic              wrInRange_p0;

    logic              vld_p1;
    logic              vld_p2;
    logic [DATA_W-1:0] pixReg;

    // ---- Stage p0: target position and slot decision (pure function of inputs) ----

    // Beam position LEAD cycles ahead, wrapping into the next line / frame.
    always_comb begin
        nxRaw_p0 = {1'b0, posX} + LEAD;
        nyInc_p0 = {1'b0, posY} + 13'd1;
        nx_p0    = nxRaw_p0;
        ny_p0    = {1'b0, posY};
        if (nxRaw_p0 >= H_P) begin
            nx_p0 = nxRaw_p0 - H_P;
            ny_p0 = (nyInc_p0 == V_P) ? 13'd0 : nyInc_p0;
        end
    end

    // A read is needed only when the target is the first screen pixel of a visible fb pixel.
    always_comb begin
        readSlot_p0  = (nx_p0 < SX_TGT) && (ny_p0 < SY_TGT)
                       && (nx_p0[SCALE_SHIFT-1:0] == '0);
        rdAddr_p0    = ADDR_W'(32'(ny_p0 >> SCALE_SHIFT) * 32'(FB_W)
                       + 32'(nx_p0 >> SCALE_SHIFT));
        wrInRange_p0 = 32'(wr_addr) < FB_PIXELS;
    end

    // Writer is granted any cycle the read schedule leaves free; never while in reset.
    assign wr_ack = !rst && wr_req && !readSlot_p0;

    // ---- Stage p1: registered RAM port ----

    // Reads take priority; out-of-range writes are acked but leave mem_we low.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (readSlot_p0) begin
            mem_addr <= rdAddr_p0;
            mem_we   <= 1'b0;
        end else if (wr_req) begin
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
            mem_we    <= wrInRange_p0;
        end else begin
            mem_we <= 1'b0;
        end
    end

    // ---- Stage p2: RAM output valid; flags follow the read through the RAM latency ----

    // Valid flags for an in-flight read; reset drops anything already issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= readSlot_p0;
            vld_p2 <= vld_p1;
        end
    end

    // ---- Stage p3: pixel hold register, lands exactly as the beam reaches the target ----

    // Capture the fetched pixel and hold it across the 2^SCALE_SHIFT screen pixels it covers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixReg <= '0;
        end else if (vld_p2) begin
            pixReg <= mem_rdata;
        end
    end

    // Blank outside the visible area regardless of what the hold register contains.
    assign pix_out = ((posX < SX_VIS) && (posY < SY_VIS)) ? pixReg : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: behavioural single-port RAM, scoreboard queues for
// expected pixels and expected RAM writes, one task per scenario.
module tb_vga_fb_arbiter;

    typedef struct packed {
        logic [15:0] addr;
        logic [11:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] posX;
    logic [11:0] posY;
    logic [11:0] pix_out;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;

    logic [11:0] ram [0:65535];
    int          fillMode;
    logic        pokeEn;
    logic [15:0] pokeAddr;
    logic [11:0] pokeData;

    int          nTests = 0;
    int          nFail  = 0;
    wr_t         wrQ[$];
    logic [11:0] pixQ[$];

    vga_fb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .posX      (posX),
        .posY      (posY),
        .pix_out   (pix_out),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] patt(input int a);
        return 12'((a * 37 + 11) ^ (a >> 4));
    endfunction

    // Synchronous single-port RAM, read-before-write, with bench fill/poke hooks.
    always @(posedge clk) begin
        if (fillMode == 1) begin
            for (int i = 0; i < 65536; i++) ram[i] <= patt(i);
        end else if (fillMode == 2) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 12'hFFF;
        end else begin
            if (pokeEn) ram[pokeAddr] <= pokeData;
            if (mem_we) ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; posX = 12'd0; posY = 12'd0;
        wr_req = 1'b1; wr_addr = 16'd7; wr_data = 12'h111;
        fillMode = 1; pokeEn = 1'b0; pokeAddr = 16'd0; pokeData = 12'h000;
        nextCycle();
        fillMode = 0; pokeEn = 1'b1; pokeAddr = 16'd0; pokeData = 12'hF00;
        nextCycle();
        pokeAddr = 16'd1; pokeData = 12'h0F0;
        nextCycle();
        pokeEn = 1'b0;
        @(negedge clk);
        nTests++; if (pix_out !== 12'h000) begin nFail++; $display("FAIL reset_pix_out: got %h want 000", pix_out); end
        nTests++; if (wr_ack !== 1'b0) begin nFail++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
        nTests++; if (mem_we !== 1'b0) begin nFail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        nTests++; if (mem_addr !== 16'd0) begin nFail++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        nTests++; if (mem_wdata !== 12'h000) begin nFail++; $display("FAIL reset_mem_wdata: got %h want 000", mem_wdata); end
        nextCycle();
        wr_req = 1'b0;
    endtask

    task automatic test_prefetch_wrap();
        logic [11:0] exp;
        logic [11:0] got;
        rst = 1'b0; wr_req = 1'b0; posY = 12'd806; posX = 12'd1326;
        nextCycle();
        posX = 12'd1327;
        @(negedge clk);
        nTests++; if (mem_addr !== 16'd0) begin nFail++; $display("FAIL wrap_mem_addr: got %h want 0000", mem_addr); end
        nTests++; if (mem_we !== 1'b0) begin nFail++; $display("FAIL wrap_mem_we: got %b want 0", mem_we); end
        nextCycle();
        posX = 12'd1328;
        nextCycle();
        for (int x = 0; x < 1329; x++) begin
            posY = 12'd0; posX = 12'(x);
            if (x >= 1024)          exp = 12'h000;
            else if ((x >> 2) == 0) exp = 12'hF00;
            else if ((x >> 2) == 1) exp = 12'h0F0;
            else                    exp = patt(x >> 2);
            pixQ.push_back(exp);
            @(negedge clk);
            got = pixQ.pop_front();
            nTests++; if (pix_out !== got) begin nFail++; $display("FAIL line0_pix x=%0d: got %h want %h", x, pix_out, got); end
            nextCycle();
        end
    endtask

    task automatic test_write_interleave();
        logic expAck;
        logic prevAck;
        wr_t  e;
        prevAck = 1'b0;
        for (int x = 0; x < 16; x++) begin
            posY = 12'd0; posX = 12'(x);
            wr_req = 1'b1; wr_addr = 16'd5; wr_data = 12'hABC;
            expAck = ((x % 4) != 1);
            @(negedge clk);
            nTests++; if (wr_ack !== expAck) begin nFail++; $display("FAIL interleave_ack x=%0d: got %b want %b", x, wr_ack, expAck); end
            if (expAck) wrQ.push_back('{addr: 16'd5, data: 12'hABC});
            nTests++; if (mem_we !== prevAck) begin nFail++; $display("FAIL interleave_we x=%0d: got %b want %b", x, mem_we, prevAck); end
            if (mem_we === 1'b1 && wrQ.size() > 0) begin
                e = wrQ.pop_front();
                nTests++; if (mem_addr !== e.addr || mem_wdata !== e.data) begin nFail++; $display("FAIL interleave_wr x=%0d: got %h/%h want %h/%h", x, mem_addr, mem_wdata, e.addr, e.data); end
            end
            prevAck = expAck;
            nextCycle();
        end
        wr_req = 1'b0;
        @(negedge clk);
        nTests++; if (mem_we !== prevAck) begin nFail++; $display("FAIL interleave_drain_we: got %b want %b", mem_we, prevAck); end
        if (mem_we === 1'b1 && wrQ.size() > 0) begin
            e = wrQ.pop_front();
            nTests++; if (mem_addr !== e.addr || mem_wdata !== e.data) begin nFail++; $display("FAIL interleave_drain_wr: got %h/%h want %h/%h", mem_addr, mem_wdata, e.addr, e.data); end
        end
        nextCycle();
    endtask

    task automatic test_back_to_back();
        logic expAck;
        logic prevAck;
        int   idx;
        wr_t  e;
        prevAck = 1'b0; idx = 0;
        for (int c = 0; c < 10; c++) begin
            posY = 12'd10; posX = 12'(1100 + c);
            if (idx < 8) begin
                wr_req = 1'b1; wr_addr = 16'(100 + idx); wr_data = 12'(idx * 291 + 1);
            end else begin
                wr_req = 1'b0;
            end
            expAck = (idx < 8);
            @(negedge clk);
            nTests++; if (wr_ack !== expAck) begin nFail++; $display("FAIL b2b_ack c=%0d: got %b want %b", c, wr_ack, expAck); end
            if (expAck) begin
                wrQ.push_back('{addr: 16'(100 + idx), data: 12'(idx * 291 + 1)});
                idx++;
            end
            nTests++; if (mem_we !== prevAck) begin nFail++; $display("FAIL b2b_we c=%0d: got %b want %b", c, mem_we, prevAck); end
            if (mem_we === 1'b1 && wrQ.size() > 0) begin
                e = wrQ.pop_front();
                nTests++; if (mem_addr !== e.addr || mem_wdata !== e.data) begin nFail++; $display("FAIL b2b_wr c=%0d: got %h/%h want %h/%h", c, mem_addr, mem_wdata, e.addr, e.data); end
            end
            prevAck = expAck;
            nextCycle();
        end
        nTests++; if (wrQ.size() != 0) begin nFail++; $display("FAIL b2b_queue: got %0d pending want 0", wrQ.size()); end
    endtask

    task automatic test_out_of_range();
        posY = 12'd10; posX = 12'd1200;
        wr_req = 1'b1; wr_addr = 16'd49152; wr_data = 12'h123;
        @(negedge clk);
        nTests++; if (wr_ack !== 1'b1) begin nFail++; $display("FAIL oor_ack: got %b want 1", wr_ack); end
        nTests++; if (mem_we !== 1'b0) begin nFail++; $display("FAIL oor_we0: got %b want 0", mem_we); end
        nextCycle();
        wr_req = 1'b0;
        for (int c = 1; c < 5; c++) begin
            posX = 12'(1200 + c);
            @(negedge clk);
            nTests++; if (wr_ack !== 1'b0) begin nFail++; $display("FAIL oor_ack_after c=%0d: got %b want 0", c, wr_ack); end
            nTests++; if (mem_we !== 1'b0) begin nFail++; $display("FAIL oor_we c=%0d: got %b want 0", c, mem_we); end
            nextCycle();
        end
        nTests++; if (ram[49152] !== patt(49152)) begin nFail++; $display("FAIL oor_ram: got %h want %h", ram[49152], patt(49152)); end
    endtask

    task automatic test_reset_midflight();
        logic [11:0] got;
        rst = 1'b0; wr_req = 1'b0; posY = 12'd20; posX = 12'd0;
        nextCycle();
        posX = 12'd1;
        nextCycle();
        posX = 12'd2; rst = 1'b1; wr_req = 1'b1; wr_addr = 16'd9; wr_data = 12'h555;
        @(negedge clk);
        nTests++; if (wr_ack !== 1'b0) begin nFail++; $display("FAIL midrst_ack_in_reset: got %b want 0", wr_ack); end
        nextCycle();
        rst = 1'b0; wr_req = 1'b0; posX = 12'd3;
        @(negedge clk);
        nTests++; if (pix_out !== 12'h000) begin nFail++; $display("FAIL midrst_pix: got %h want 000", pix_out); end
        nTests++; if (mem_we !== 1'b0) begin nFail++; $display("FAIL midrst_we: got %b want 0", mem_we); end
        nTests++; if (wr_ack !== 1'b0) begin nFail++; $display("FAIL midrst_ack: got %b want 0", wr_ack); end
        nextCycle();
        for (int x = 4; x < 9; x++) begin
            posX = 12'(x);
            pixQ.push_back((x < 8) ? 12'h000 : patt(5 * 256 + 2));
            @(negedge clk);
            got = pixQ.pop_front();
            nTests++; if (pix_out !== got) begin nFail++; $display("FAIL midrst_pix x=%0d: got %h want %h", x, pix_out, got); end
            nTests++; if (mem_we !== 1'b0) begin nFail++; $display("FAIL midrst_we x=%0d: got %b want 0", x, mem_we); end
            nextCycle();
        end
    endtask

    task automatic test_blank_rows();
        logic        prevAck;
        logic [11:0] d;
        wr_t         e;
        wr_req = 1'b0; fillMode = 2;
        nextCycle();
        fillMode = 0;
        prevAck = 1'b0;
        for (int x = 0; x < 1329; x++) begin
            d = 12'($urandom);
            posY = 12'd770; posX = 12'(x);
            wr_req = 1'b1; wr_addr = 16'(300 + x); wr_data = d;
            @(negedge clk);
            nTests++; if (pix_out !== 12'h000) begin nFail++; $display("FAIL blank_pix x=%0d: got %h want 000", x, pix_out); end
            nTests++; if (wr_ack !== 1'b1) begin nFail++; $display("FAIL blank_ack x=%0d: got %b want 1", x, wr_ack); end
            wrQ.push_back('{addr: 16'(300 + x), data: d});
            nTests++; if (mem_we !== prevAck) begin nFail++; $display("FAIL blank_we x=%0d: got %b want %b", x, mem_we, prevAck); end
            if (mem_we === 1'b1 && wrQ.size() > 0) begin
                e = wrQ.pop_front();
                nTests++; if (mem_addr !== e.addr || mem_wdata !== e.data) begin nFail++; $display("FAIL blank_wr x=%0d: got %h/%h want %h/%h", x, mem_addr, mem_wdata, e.addr, e.data); end
            end
            prevAck = 1'b1;
            nextCycle();
        end
        wr_req = 1'b0;
        @(negedge clk);
        nTests++; if (mem_we !== 1'b1) begin nFail++; $display("FAIL blank_drain_we: got %b want 1", mem_we); end
        if (mem_we === 1'b1 && wrQ.size() > 0) begin
            e = wrQ.pop_front();
            nTests++; if (mem_addr !== e.addr || mem_wdata !== e.data) begin nFail++; $display("FAIL blank_drain_wr: got %h/%h want %h/%h", mem_addr, mem_wdata, e.addr, e.data); end
        end
        nextCycle();
        nTests++; if (wrQ.size() != 0) begin nFail++; $display("FAIL blank_queue: got %0d pending want 0", wrQ.size()); end
    endtask

    initial begin
        rst = 1'b1; posX = 12'd0; posY = 12'd0;
        wr_req = 1'b0; wr_addr = 16'd0; wr_data = 12'h000;
        fillMode = 0; pokeEn = 1'b0; pokeAddr = 16'd0; pokeData = 12'h000;
        test_reset();
        test_prefetch_wrap();
        test_write_interleave();
        test_back_to_back();
        test_out_of_range();
        test_reset_midflight();
        test_blank_rows();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
